mem_port_resp: RTL and testbench

MEM_PORT_RESP -- requirements
Module: mem_port_resp

---
 rtl/mem_port_resp_pkg.sv | 18 +
 rtl/mem_port_resp_if.sv | 45 ++++
 rtl/mem_port_resp.sv | 113 +++++++++++
 tb/tb_mem_port_resp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_resp_pkg.sv
// Shared definitions for the frame-buffer memory port:
// reset/enable polarity constants and FSM state encodings.
package mem_port_resp_pkg;

  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_resp_if.sv
// Frame-buffer request side plus Avalon-MM master side of the port.
// slave is the port logic's view, master is the surrounding system's.
interface mem_port_resp_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_rdy;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_valid;

  logic [ADDR_W-1:0] avl_addr;
  logic [DATA_W-1:0] avl_wdata;
  logic              avl_write;
  logic              avl_read;
  logic              avl_ready;
  logic [DATA_W-1:0] avl_rdata;
  logic              avl_rdata_valid;
  logic              err;

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr,
    input  avl_ready, avl_rdata, avl_rdata_valid,
    output wr_rdy, rd_rdy, rd_data, rd_data_valid,
    output avl_addr, avl_wdata, avl_write, avl_read,
    output err
  );

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr,
    output avl_ready, avl_rdata, avl_rdata_valid,
    input  wr_rdy, rd_rdy, rd_data, rd_data_valid,
    input  avl_addr, avl_wdata, avl_write, avl_read,
    input  err
  );

endinterface

// File: rtl/mem_port_resp.sv
// Single-command Avalon-MM master for a frame buffer, with an
// outstanding-read tracker and one-cycle registered read return.
module mem_port_resp
  import mem_port_resp_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int MAX_RD = 4
) (
  input logic clk,
  input logic reset,
  mem_port_resp_if.slave bus
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic              write_q, write_n;
  logic              read_q, read_n;
  logic [CNT_W-1:0]  rd_cnt, rd_cnt_n;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              err_q;

  logic idle;
  logic issue;
  logic ret_ok;

  assign idle  = (state == IDLE) && (reset == DEASSERT_L);
  assign issue = read_q && bus.avl_ready;

  // A return is legal if a read is outstanding or being issued now.
  assign ret_ok = bus.avl_rdata_valid
               && ((rd_cnt != '0) || issue);

  assign bus.wr_rdy = idle;
  assign bus.rd_rdy = idle && !bus.wr_en
                   && (rd_cnt < CNT_W'(MAX_RD));

  assign bus.avl_addr      = addr_q;
  assign bus.avl_wdata     = wdata_q;
  assign bus.avl_write     = write_q;
  assign bus.avl_read      = read_q;
  assign bus.rd_data       = rdata_q;
  assign bus.rd_data_valid = rvalid_q;
  assign bus.err           = err_q;

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    write_n = write_q;
    read_n  = read_q;
    unique case (state)
      IDLE: begin
        if (bus.wr_en && bus.wr_rdy) begin
          addr_n  = bus.wr_addr;
          wdata_n = bus.wr_data;
          write_n = ASSERT_H;
          state_n = WR;
        end else if (bus.rd_en && bus.rd_rdy) begin
          addr_n  = bus.rd_addr;
          read_n  = ASSERT_H;
          state_n = RD;
        end
      end
      WR, RD: begin
        if (bus.avl_ready) begin
          write_n = DEASSERT_H;
          read_n  = DEASSERT_H;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rd_cnt_n = rd_cnt;
    unique case ({issue, ret_ok})
      2'b10:   rd_cnt_n = rd_cnt + 1'b1;
      2'b01:   rd_cnt_n = rd_cnt - 1'b1;
      default: rd_cnt_n = rd_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset == ASSERT_L) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= DEASSERT_H;
      read_q   <= DEASSERT_H;
      rd_cnt   <= '0;
      rdata_q  <= '0;
      rvalid_q <= DEASSERT_H;
      err_q    <= DEASSERT_H;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      write_q  <= write_n;
      read_q   <= read_n;
      rd_cnt   <= rd_cnt_n;
      rvalid_q <= ret_ok;
      if (ret_ok)
        rdata_q <= bus.avl_rdata;
      if (bus.avl_rdata_valid && !ret_ok)
        err_q <= ASSERT_H;
    end
  end

endmodule

// File: tb/tb_mem_port_resp.sv
// Randomized + directed bench for mem_port_resp against a
// transaction-level model of the port and its controller.
module tb_mem_port_resp;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int MR = 4;

  logic clk;
  logic rst_n;

  mem_port_resp_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_resp #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_RD(MR)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model: one pending command, outstanding read count, last return.
  bit          m_busy;
  bit          m_isrd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  bit          m_rvalid;
  bit          m_err;
  int          m_out;
  int          ctrl_pend;

  task automatic chk(string name, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    bit rr;
    rr = rst_n && !m_busy && !bus.wr_en && (m_out < MR);
    chk("avl_write", DW'(bus.avl_write), DW'(m_busy && !m_isrd));
    chk("avl_read", DW'(bus.avl_read), DW'(m_busy && m_isrd));
    chk("excl", DW'(bus.avl_write & bus.avl_read), '0);
    chk("avl_addr", DW'(bus.avl_addr), DW'(m_addr));
    chk("avl_wdata", bus.avl_wdata, m_wdata);
    chk("wr_rdy", DW'(bus.wr_rdy), DW'(rst_n && !m_busy));
    chk("rd_rdy", DW'(bus.rd_rdy), DW'(rr));
    chk("rd_data", bus.rd_data, m_rdata);
    chk("rd_data_valid", DW'(bus.rd_data_valid), DW'(m_rvalid));
    chk("err", DW'(bus.err), DW'(m_err));
  endtask

  task automatic model_update();
    bit iss, wg, rg, ok;
    iss = m_busy && m_isrd && bus.avl_ready;
    wg  = rst_n && !m_busy && bus.wr_en;
    rg  = rst_n && !m_busy && !bus.wr_en && bus.rd_en
       && (m_out < MR);
    if (bus.avl_rdata_valid && ctrl_pend > 0) ctrl_pend--;
    if (iss) ctrl_pend++;
    if (!rst_n) begin
      m_busy = 0; m_isrd = 0; m_addr = '0; m_wdata = '0;
      m_rdata = '0; m_rvalid = 0; m_err = 0; m_out = 0;
    end else begin
      ok = bus.avl_rdata_valid && (m_out > 0 || iss);
      if (bus.avl_rdata_valid && !ok) m_err = 1;
      m_rvalid = ok;
      if (ok) m_rdata = bus.avl_rdata;
      m_out = m_out + int'(iss) - int'(ok);
      if (m_busy) begin
        if (bus.avl_ready) m_busy = 0;
      end else if (wg) begin
        m_busy = 1; m_isrd = 0;
        m_addr = bus.wr_addr; m_wdata = bus.wr_data;
      end else if (rg) begin
        m_busy = 1; m_isrd = 1;
        m_addr = bus.rd_addr;
      end
    end
  endtask

  // Called at a falling edge with inputs already set.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.wr_en = 0; bus.rd_en = 0;
    bus.avl_rdata_valid = 0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_busy = 0; m_isrd = 0; m_addr = '0; m_wdata = '0;
    m_rdata = '0; m_rvalid = 0; m_err = 0; m_out = 0;
    ctrl_pend = 0;
    rst_n = 0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 0; bus.rd_addr = '0;
    bus.avl_ready = 0; bus.avl_rdata = '0;
    bus.avl_rdata_valid = 0;
    @(negedge clk);
    bus.wr_en = 1;
    cycle();
    cycle();
    chk("rst wr_rdy", DW'(bus.wr_rdy), '0);
    chk("rst avl_write", DW'(bus.avl_write), '0);
    chk("rst err", DW'(bus.err), '0);
    idle_inputs();
    rst_n = 1;

    // Write with zero-wait controller
    bus.wr_en = 1; bus.wr_addr = 24'h000007;
    bus.wr_data = 32'h00FFFFFF; bus.avl_ready = 1;
    cycle();
    bus.wr_en = 0;
    chk("wr avl_write", DW'(bus.avl_write), 1);
    chk("wr avl_addr", DW'(bus.avl_addr), 7);
    chk("wr avl_wdata", bus.avl_wdata, 32'h00FFFFFF);
    chk("wr busy wr_rdy", DW'(bus.wr_rdy), 0);
    cycle();
    chk("wr done avl_write", DW'(bus.avl_write), 0);
    chk("wr done wr_rdy", DW'(bus.wr_rdy), 1);

    // Read under 5 cycles of backpressure
    bus.rd_en = 1; bus.rd_addr = 24'h3; bus.avl_ready = 0;
    cycle();
    bus.rd_en = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp avl_read", DW'(bus.avl_read), 1);
      chk("bp avl_addr", DW'(bus.avl_addr), 3);
      chk("bp rd_rdy", DW'(bus.rd_rdy), 0);
      cycle();
    end
    bus.avl_ready = 1;
    chk("bp last avl_read", DW'(bus.avl_read), 1);
    cycle();
    chk("bp done avl_read", DW'(bus.avl_read), 0);
    bus.avl_rdata_valid = 1; bus.avl_rdata = 32'h12345678;
    cycle();
    bus.avl_rdata_valid = 0;
    chk("bp rd_data_valid", DW'(bus.rd_data_valid), 1);
    chk("bp rd_data", bus.rd_data, 32'h12345678);
    cycle();
    chk("bp pulse end", DW'(bus.rd_data_valid), 0);
    chk("bp rd_data hold", bus.rd_data, 32'h12345678);

    // Simultaneous write and read
    bus.wr_en = 1; bus.rd_en = 1;
    bus.wr_addr = 24'h10; bus.rd_addr = 24'h20;
    cycle();
    bus.wr_en = 0;
    chk("sim avl_write", DW'(bus.avl_write), 1);
    chk("sim avl_addr w", DW'(bus.avl_addr), 24'h10);
    cycle();
    chk("sim rd_rdy", DW'(bus.rd_rdy), 1);
    cycle();
    bus.rd_en = 0;
    chk("sim avl_read", DW'(bus.avl_read), 1);
    chk("sim avl_addr r", DW'(bus.avl_addr), 24'h20);
    cycle();
    bus.avl_rdata_valid = 1; bus.avl_rdata = 32'hCAFE0001;
    cycle();
    bus.avl_rdata_valid = 0;

    // Outstanding limit
    for (int i = 0; i < MR; i++) begin
      bus.rd_en = 1; bus.rd_addr = AW'(i + 8);
      cycle();
      bus.rd_en = 0;
      cycle();
    end
    bus.rd_en = 1;
    #1;
    chk("lim rd_rdy", DW'(bus.rd_rdy), 0);
    cycle();
    bus.rd_en = 0;
    chk("lim no issue", DW'(bus.avl_read), 0);
    bus.avl_rdata_valid = 1; bus.avl_rdata = 32'hA5A5A5A5;
    cycle();
    bus.avl_rdata_valid = 0;
    chk("lim rd_data_valid", DW'(bus.rd_data_valid), 1);
    chk("lim rd_data", bus.rd_data, 32'hA5A5A5A5);
    chk("lim rd_rdy again", DW'(bus.rd_rdy), 1);
    for (int i = 0; i < MR - 1; i++) begin
      bus.avl_rdata_valid = 1; bus.avl_rdata = DW'(i);
      cycle();
    end
    bus.avl_rdata_valid = 0;
    cycle();

    // Spurious return
    bus.avl_rdata_valid = 1; bus.avl_rdata = 32'hDEAD;
    cycle();
    bus.avl_rdata_valid = 0;
    chk("err no valid", DW'(bus.rd_data_valid), 0);
    chk("err set", DW'(bus.err), 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("err sticky", DW'(bus.err), 1);
    rst_n = 0;
    cycle();
    rst_n = 1;
    chk("err cleared", DW'(bus.err), 0);

    // Reset mid-write under backpressure
    bus.wr_en = 1; bus.wr_addr = 24'h55;
    bus.wr_data = 32'h11; bus.avl_ready = 0;
    cycle();
    bus.wr_en = 0;
    cycle();
    chk("rw avl_write", DW'(bus.avl_write), 1);
    rst_n = 0;
    cycle();
    chk("rw avl_write clr", DW'(bus.avl_write), 0);
    chk("rw avl_addr clr", DW'(bus.avl_addr), 0);
    chk("rw avl_wdata clr", bus.avl_wdata, 0);
    chk("rw wr_rdy low", DW'(bus.wr_rdy), 0);
    rst_n = 1;
    #1;
    chk("rw wr_rdy idle", DW'(bus.wr_rdy), 1);

    // Randomized traffic with a random-latency controller
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      bus.wr_en = ($urandom_range(0, 9) < 3);
      bus.rd_en = ($urandom_range(0, 9) < 5);
      bus.wr_addr = AW'($urandom);
      bus.rd_addr = AW'($urandom);
      bus.wr_data = $urandom;
      bus.avl_ready = ($urandom_range(0, 9) < 7);
      bus.avl_rdata = $urandom;
      bus.avl_rdata_valid = (ctrl_pend > 0)
                         && ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
